// File: rtl/rf_command_qualifier_if.sv
// RF receiver link bundle: raw receiver pins in, qualified command out.
// master = receiver/stimulus side, slave = the command qualifier.
interface rf_command_qualifier_if;
  logic [3:0] rf_data;
  logic       rf_vt;
  logic [3:0] RF_sensor;
  logic       cmd_valid;
  logic       cmd_strobe;
  logic       link_lost;

  modport master (
    output rf_data, rf_vt,
    input  RF_sensor, cmd_valid, cmd_strobe, link_lost
  );

  modport slave (
    input  rf_data, rf_vt,
    output RF_sensor, cmd_valid, cmd_strobe, link_lost
  );
endinterface

// File: rtl/rf_command_qualifier.sv
// Synchronizes the RF receiver pins, accepts a code after STABLE_CYCLES matching samples and
// forces stop after HOLD_CYCLES of lost VT. Define RF_LATCH_EN to hold the last code forever instead.
module rf_command_qualifier #(
  parameter int STABLE_CYCLES = 100_000,
  parameter int HOLD_CYCLES   = 20_000_000
) (
  input logic                   CLK,
  input logic                   RST_N,
  rf_command_qualifier_if.slave rf
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [SW-1:0] STAB_MAX  = SW'(STABLE_CYCLES);

  typedef enum logic [1:0] {IDLE, QUALIFY, ACTIVE, HOLD} state_e;

  state_e        state_q, state_d;
  logic [3:0]    data_m_q, data_s_q;
  logic          vt_m_q, vt_s_q;
  logic [3:0]    cand_q, cand_d;
  logic [SW-1:0] stab_cnt_q, stab_cnt_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          strobe_q, strobe_d;
  logic          lost_q, lost_d;
  logic          timeout;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      data_m_q <= '0;
      data_s_q <= '0;
      vt_m_q   <= 1'b0;
      vt_s_q   <= 1'b0;
    end else begin
      data_m_q <= rf.rf_data;
      data_s_q <= data_m_q;
      vt_m_q   <= rf.rf_vt;
      vt_s_q   <= vt_m_q;
    end
  end

`ifndef RF_LATCH_EN
  localparam int TW = $clog2(HOLD_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(HOLD_CYCLES);

  logic [TW-1:0] to_cnt_q, to_cnt_d;

  always_comb begin
    to_cnt_d = to_cnt_q;
    timeout  = 1'b0;
    if (vt_s_q) begin
      to_cnt_d = '0;
    end else if (valid_q) begin
      timeout = (to_cnt_q == TO_LAST);
      if (to_cnt_q != TO_MAX) to_cnt_d = to_cnt_q + TW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) to_cnt_q <= '0;
    else        to_cnt_q <= to_cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    stab_cnt_d = stab_cnt_q;
    code_d     = code_q;
    valid_d    = valid_q;
    strobe_d   = 1'b0;
    lost_d     = lost_q;
    // Forced stop wins over any qualification activity in the same cycle.
    if (timeout) begin
      state_d = IDLE;
      code_d  = '0;
      valid_d = 1'b0;
      lost_d  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (vt_s_q) begin
            state_d    = QUALIFY;
            cand_d     = data_s_q;
            stab_cnt_d = SW'(1);
          end
        end
        QUALIFY: begin
          if (!vt_s_q) begin
            state_d = valid_q ? HOLD : IDLE;
          end else if (data_s_q != cand_q) begin
            cand_d     = data_s_q;
            stab_cnt_d = SW'(1);
          end else begin
            if (stab_cnt_q != STAB_MAX) stab_cnt_d = stab_cnt_q + SW'(1);
            if (stab_cnt_q == STAB_LAST) begin
              state_d  = ACTIVE;
              code_d   = cand_q;
              valid_d  = 1'b1;
              strobe_d = 1'b1;
              lost_d   = 1'b0;
            end
          end
        end
        ACTIVE, HOLD: begin
          if (!vt_s_q) begin
            state_d = HOLD;
          end else if (data_s_q == code_q) begin
            state_d = ACTIVE;
          end else begin
            state_d    = QUALIFY;
            cand_d     = data_s_q;
            stab_cnt_d = SW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      cand_q     <= '0;
      stab_cnt_q <= '0;
      code_q     <= '0;
      valid_q    <= 1'b0;
      strobe_q   <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      stab_cnt_q <= stab_cnt_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      strobe_q   <= strobe_d;
      lost_q     <= lost_d;
    end
  end

  assign rf.RF_sensor  = code_q;
  assign rf.cmd_valid  = valid_q;
  assign rf.cmd_strobe = strobe_q;
  assign rf.link_lost  = lost_q;

endmodule

// File: doc/rf_command_qualifier.md
# rf_command_qualifier

Front-end for the rover's RF remote link. Samples the raw 4-bit data lines and valid-transmission (VT) pin of the RF receiver module, synchronizes them, and accepts a command only after it has been stable for a programmable number of cycles. It then presents that command as the `RF_sensor` code consumed by `rover_sensors`. A command whose transmission has stopped is held for a bounded time and then forced to 0 (stop), so a lost link never leaves the motors running.

## Interface
- `STABLE_CYCLES`, default 100_000: consecutive matching synchronized samples required to accept a code (1 ms @ 100 MHz); must be ≥2.
- `HOLD_CYCLES`, default 20_000_000: cycles with VT low, while a command is valid, before forced stop (200 ms @ 100 MHz); must be ≥1.
- `CLK`  in  1  system clock; all state changes on the rising edge.
- `RST_N`  in  1  reset, asynchronous, active-low.
- `rf_data`  in  4  raw receiver data D3..D0; asynchronous to `CLK`.
- `rf_vt`  in  1  raw receiver valid-transmission flag; asynchronous to `CLK`.
- `RF_sensor`  out  4  accepted command code, registered; drives `rover_sensors.RF_sensor`.
- `cmd_valid`  out  1  high while `RF_sensor` holds an accepted code.
- `cmd_strobe`  out  1  one-cycle pulse on each acceptance.
- `link_lost`  out  1  sticky flag set on timeout; cleared on the next acceptance.

## Operation
- Input synchronization: `rf_data` and `rf_vt` each pass through a 2-flop synchronizer, producing `data_s` and `vt_s`. No other logic samples the raw pins.
- State machine states: IDLE, QUALIFY, ACTIVE, HOLD.
- **IDLE**
  - Outputs: `RF_sensor`=0, `cmd_valid`=0.
  - `vt_s`=1 → go to QUALIFY; `cand`←`data_s`, `stab_cnt`←1.
- **QUALIFY**
  - `vt_s`=1 and `data_s`==`cand`: `stab_cnt`++.
  - On reaching `STABLE_CYCLES`: `RF_sensor`←`cand`, `cmd_valid`←1, `cmd_strobe`=1 for one cycle, `link_lost`←0, go to ACTIVE.
  - `vt_s`=1 and `data_s`≠`cand`: `cand`←`data_s`, `stab_cnt`←1, stay in QUALIFY.
  - `vt_s`=0: go to HOLD if `cmd_valid`, else IDLE.
  - `RF_sensor` keeps its previous value throughout QUALIFY, so there is no glitch between codes.
- **ACTIVE**
  - `vt_s`=1 and `data_s`==`RF_sensor`: stay.
  - `vt_s`=1 and `data_s` differs: go to QUALIFY (`cand`←`data_s`, `stab_cnt`←1).
  - `vt_s`=0: go to HOLD.
- **HOLD**
  - `vt_s`=1 and `data_s`==`RF_sensor`: go to ACTIVE. No strobe is issued.
  - `vt_s`=1 and `data_s` differs: go to QUALIFY.
- **Timeout counter `to_cnt`**
  - Increments on every cycle with `cmd_valid`=1 and `vt_s`=0; cleared on any cycle with `vt_s`=1.
  - On reaching `HOLD_CYCLES`: `RF_sensor`←0, `cmd_valid`←0, `link_lost`←1, go to IDLE.
  - Timeout has priority over all other transitions in the same cycle.
- Code 0 carries no special meaning: with VT high it qualifies and is accepted like any other code.
- Arithmetic and widths:
  - `stab_cnt` is `$clog2(STABLE_CYCLES+1)` bits and `to_cnt` is `$clog2(HOLD_CYCLES+1)` bits.
  - Both counters saturate and never wrap.
- Re-acceptance: reaching `STABLE_CYCLES` on a `cand` equal to the current `RF_sensor` still strobes.

## Timing
- Reset values:
  - `RF_sensor`=0, `cmd_valid`=0, `cmd_strobe`=0, `link_lost`=0.
  - State IDLE; synchronizers and counters cleared.
- Reset acts immediately on assertion, including mid-QUALIFY or mid-ACTIVE; outputs go to 0 without waiting for a clock edge.
- Acceptance latency: inputs settled before edge k → `RF_sensor`, `cmd_valid` and `cmd_strobe` update at edge k+1+`STABLE_CYCLES`. This comprises 2 synchronizer stages plus `STABLE_CYCLES` samples, counting the first sample at k+2.
- Timeout latency: VT low from edge k → forced stop at edge k+1+`HOLD_CYCLES`.
- `cmd_strobe` is never high on two consecutive cycles.

## Configuration
- `RF_LATCH_EN` defined:
  - The timeout is removed; HOLD persists indefinitely and the last accepted code stays on `RF_sensor` until a new code qualifies or reset is asserted.
  - `link_lost` is tied to 0, and `to_cnt` is not built.
- `RF_LATCH_EN` undefined: timeout behaviour exactly as specified above.

## Test plan
Bench parameters: `STABLE_CYCLES`=4, `HOLD_CYCLES`=8, 10 ns clock.
- Reset: `RST_N`=0 mid-ACTIVE with `RF_sensor`=5 → all outputs 0 immediately; after release, state is IDLE.
- Accept: `rf_vt`=1, `rf_data`=5 from edge 0 → `RF_sensor`=5, `cmd_valid`=1, and a single `cmd_strobe` at edge 5; no further strobes while held.
- Glitch reject: `rf_data`=3 with VT high for 3 cycles, then VT low → `RF_sensor`, `cmd_valid` and `cmd_strobe` unchanged (0).
- Code change: from ACTIVE with 5, switch `rf_data` to 9 with VT high → `RF_sensor`=5 through QUALIFY, then 9 after 4 stable samples, with exactly one strobe.
- Dropout: VT low for 7 cycles then high with 5 → no output change, no strobe. VT low for ≥9 cycles → `RF_sensor`=0, `cmd_valid`=0, `link_lost`=1.
- `RF_LATCH_EN`: same dropout for 100 cycles → `RF_sensor` stays 5 and `link_lost` stays 0.
